// File: rtl/cpu_pkg.sv
// Shared miniCPU definitions: instruction width, opcodes and sequencer states.
package cpu_pkg;

  localparam int INSTR_W = 18;

  // opcode field, instr[17:15]
  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLR     = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Board keys/switches on one side, datapath handshake and status on the other.
interface instr_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                        enviar;
  logic                        executar;
  logic                        modo;
  logic [cpu_pkg::INSTR_W-1:0] switches;
  logic [cpu_pkg::INSTR_W-1:0] instr_out;
  logic                        issue_start;
  logic                        exec_done;
  logic [CW-1:0]               q_count;
  logic                        q_full;
  logic                        q_empty;
  logic                        busy;
  logic                        err_overflow;
  logic                        err_timeout;

  // sequencer side
  modport slave (
    input  enviar, executar, modo, switches, exec_done,
    output instr_out, issue_start, q_count, q_full, q_empty, busy,
           err_overflow, err_timeout
  );

  // board / datapath side
  modport master (
    output enviar, executar, modo, switches, exec_done,
    input  instr_out, issue_start, q_count, q_full, q_empty, busy,
           err_overflow, err_timeout
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO; count is the only occupancy source, push+pop keeps it.
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // storage needs no reset; it is only read below r_count
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/instr_sequencer.sv
// Key-driven instruction queue and one-at-a-time issue scheduler for the miniCPU.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             ligar,
  instr_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  seq_state_t           r_state, w_next;
  logic                 r_env_prev, r_exe_prev;
  logic                 r_drain, r_err_ovf, r_err_to;
  logic [INSTR_W-1:0]   r_instr;
  logic [TW-1:0]        r_tcnt;

  logic [INSTR_W-1:0]   w_head;
  logic [CW-1:0]        w_count;
  logic                 w_env_press, w_exe_press;
  logic                 w_empty, w_full, w_run_ok;
  logic                 w_push, w_pop, w_tmo;
  logic                 w_issue, w_busy;

  assign w_env_press = r_env_prev & ~bus.enviar;
  assign w_exe_press = r_exe_prev & ~bus.executar;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == CW'(DEPTH));
  assign w_run_ok    = ~bus.modo | r_drain;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty & w_run_ok;
  // a full queue still accepts a press when the head leaves the same cycle
  assign w_push      = w_env_press & (~w_full | w_pop);
  assign w_tmo       = (r_tcnt == TW'(TIMEOUT - 1));

  instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (ligar),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.switches),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  // next state and handshake outputs
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_pop) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        w_next  = bus.exec_done ? S_GAP : S_WAIT_DONE;
      end
      S_WAIT_DONE: if (bus.exec_done || w_tmo) w_next = S_GAP;
      S_GAP:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // state, key history, drain, errors, issued word and timeout counter
  always_ff @(posedge clk) begin
    if (!ligar) begin
      r_state    <= S_IDLE;
      r_env_prev <= 1'b1;
      r_exe_prev <= 1'b1;
      r_drain    <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_to   <= 1'b0;
      r_instr    <= '0;
      r_tcnt     <= '0;
    end else begin
      r_state    <= w_next;
      r_env_prev <= bus.enviar;
      r_exe_prev <= bus.executar;
      if (w_exe_press && bus.modo)           r_drain <= 1'b1;
      else if (r_state == S_IDLE && w_empty) r_drain <= 1'b0;
      if (w_env_press && !w_push) r_err_ovf <= 1'b1;
      if (w_pop) r_instr <= w_head;
      // completion wins over a timeout landing on the same cycle
      if (r_state == S_WAIT_DONE && !bus.exec_done && w_tmo) r_err_to <= 1'b1;
      if (r_state == S_ISSUE)                      r_tcnt <= '0;
      else if (r_state == S_WAIT_DONE && !w_tmo)   r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign bus.instr_out    = r_instr;
  assign bus.issue_start  = w_issue;
  assign bus.busy         = w_busy;
  assign bus.q_count      = w_count;
  assign bus.q_full       = w_full;
  assign bus.q_empty      = w_empty;
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_timeout  = r_err_to;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: direct issue, batch drain, overflow, full push+pop, timeout, reset.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic ligar;
  int   n_chk = 0;
  int   n_fail = 0;

  instr_sequencer_if #(.DEPTH(8)) bus ();

  instr_sequencer #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .ligar (ligar),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_instr"}, 32'(bus.instr_out), 0);
    check({tag, "_issue"}, 32'(bus.issue_start), 0);
    check({tag, "_cnt"},   32'(bus.q_count), 0);
    check({tag, "_empty"}, 32'(bus.q_empty), 1);
    check({tag, "_full"},  32'(bus.q_full), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_ovf"},   32'(bus.err_overflow), 0);
    check({tag, "_tmo"},   32'(bus.err_timeout), 0);
  endtask

  // key low across one edge; returns on the negedge after that edge
  task automatic press(input logic [17:0] w);
    bus.switches = w;
    bus.enviar   = 1'b0;
    @(negedge clk);
    bus.enviar   = 1'b1;
  endtask

  task automatic pulse_done();
    bus.exec_done = 1'b1;
    @(negedge clk);
    bus.exec_done = 1'b0;
  endtask

  task automatic wait_issue(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (bus.issue_start) ok = 1'b1;
    end
  endtask

  // wait for an issue, confirm the word, hold off one cycle, then complete it
  task automatic serve(input string tag, input logic [17:0] w);
    bit ok;
    wait_issue(8, ok);
    check({tag, "_seen"}, 32'(ok), 1);
    check({tag, "_instr"}, 32'(bus.instr_out), 32'(w));
    @(negedge clk);
    check({tag, "_held"}, 32'(bus.issue_start), 0);
    pulse_done();
  endtask

  localparam logic [17:0] W1 = 18'b000_0001_0000_0000101;
  localparam logic [17:0] W2 = 18'h0A5A5;
  localparam logic [17:0] W3 = 18'h1C3C3;
  localparam logic [17:0] W4 = 18'h26969;
  localparam logic [17:0] W5 = 18'h31111;
  localparam logic [17:0] WX = 18'h3FFFE;
  localparam logic [17:0] T1 = 18'h05001;
  localparam logic [17:0] T2 = 18'h15002;
  logic [17:0] ow [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) ow[i] = 18'(32'h2000 + 32'(i) * 32'h1111);
    ligar = 1'b0;
    bus.enviar = 1'b1; bus.executar = 1'b1; bus.modo = 1'b0;
    bus.exec_done = 1'b0; bus.switches = '0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    ligar = 1'b1;
    @(negedge clk);

    // direct mode: issue two edges after the press
    press(W1);
    check("dir_cnt", 32'(bus.q_count), 1);
    check("dir_early", 32'(bus.issue_start), 0);
    @(negedge clk);
    check("dir_issue", 32'(bus.issue_start), 1);
    check("dir_instr", 32'(bus.instr_out), 32'(W1));
    check("dir_popped", 32'(bus.q_count), 0);
    @(negedge clk);
    check("dir_pulse1", 32'(bus.issue_start), 0);
    check("dir_busy_wait", 32'(bus.busy), 1);
    @(negedge clk);
    pulse_done();
    check("dir_busy_gap", 32'(bus.busy), 1);
    @(negedge clk);
    check("dir_idle", 32'(bus.busy), 0);

    // batch: record three, nothing issues until executar
    bus.modo = 1'b1;
    @(negedge clk);
    press(W2); @(negedge clk);
    press(W3); @(negedge clk);
    press(W4); @(negedge clk);
    check("bat_cnt", 32'(bus.q_count), 3);
    check("bat_hold", 32'(bus.busy), 0);
    bus.executar = 1'b0;
    @(negedge clk);
    bus.executar = 1'b1;
    serve("bat0", W2);
    serve("bat1", W3);
    serve("bat2", W4);
    repeat (3) @(negedge clk);
    check("bat_empty", 32'(bus.q_empty), 1);
    // drain must have dropped: a new entry stays queued
    press(W5);
    repeat (3) @(negedge clk);
    check("drain_clr_cnt", 32'(bus.q_count), 1);
    check("drain_clr_busy", 32'(bus.busy), 0);

    // fill to DEPTH without overflow
    for (int i = 0; i < 7; i++) begin
      press(ow[i]);
      @(negedge clk);
    end
    check("fill_cnt", 32'(bus.q_count), 8);
    check("fill_full", 32'(bus.q_full), 1);
    check("fill_ovf", 32'(bus.err_overflow), 0);

    // full queue: press lands on the same edge as the first pop
    bus.executar = 1'b0;
    @(negedge clk);
    bus.executar = 1'b1;
    bus.switches = WX;
    bus.enviar   = 1'b0;
    @(negedge clk);
    bus.enviar   = 1'b1;
    check("pp_issue", 32'(bus.issue_start), 1);
    check("pp_instr", 32'(bus.instr_out), 32'(W5));
    check("pp_cnt", 32'(bus.q_count), 8);
    check("pp_ovf", 32'(bus.err_overflow), 0);
    @(negedge clk);
    // ninth word while full with no pop: dropped
    press(ow[7]);
    check("ovf_flag", 32'(bus.err_overflow), 1);
    check("ovf_cnt", 32'(bus.q_count), 8);
    pulse_done();
    for (int i = 0; i < 7; i++) serve($sformatf("drn%0d", i), ow[i]);
    serve("drnX", WX);
    repeat (4) @(negedge clk);
    check("drn_empty", 32'(bus.q_empty), 1);
    check("drn_idle", 32'(bus.busy), 0);

    // timeout: first entry never completes, second issues normally
    bus.modo = 1'b0;
    @(negedge clk);
    press(T1);
    @(negedge clk);
    check("tmo_issue", 32'(bus.issue_start), 1);
    check("tmo_instr", 32'(bus.instr_out), 32'(T1));
    press(T2);
    repeat (15) @(negedge clk);
    check("tmo_early", 32'(bus.err_timeout), 0);
    check("tmo_wait", 32'(bus.busy), 1);
    check("tmo_q", 32'(bus.q_count), 1);
    @(negedge clk);
    check("tmo_flag", 32'(bus.err_timeout), 1);
    check("tmo_gap", 32'(bus.busy), 1);
    @(negedge clk);
    check("tmo_idle", 32'(bus.busy), 0);
    @(negedge clk);
    check("tmo_next", 32'(bus.issue_start), 1);
    check("tmo_next_instr", 32'(bus.instr_out), 32'(T2));
    @(negedge clk);
    pulse_done();
    repeat (2) @(negedge clk);
    check("tmo_sticky", 32'(bus.err_timeout), 1);
    check("tmo_done", 32'(bus.busy), 0);

    // reset during WAIT_DONE with four queued
    press(W2); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      press(ow[i]);
      @(negedge clk);
    end
    check("mid_cnt", 32'(bus.q_count), 4);
    check("mid_busy", 32'(bus.busy), 1);
    ligar = 1'b0;
    @(negedge clk);
    ligar = 1'b1;
    check_reset("mid_rst");
    pulse_done();
    @(negedge clk);
    check("late_done_busy", 32'(bus.busy), 0);
    check("late_done_issue", 32'(bus.issue_start), 0);
    check("late_done_cnt", 32'(bus.q_count), 0);
    press(W3);
    @(negedge clk);
    check("post_rst_issue", 32'(bus.issue_start), 1);
    check("post_rst_instr", 32'(bus.instr_out), 32'(W3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
